// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with write-through bypass,
// per-entry valid bits, optional zero entry and a clear sequencer.
module regfile_2r1w #(
  parameter int DATA_W   = 15,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr_a,
  output logic [DATA_W-1:0] r_data_a,
  output logic              r_valid_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_b,
  output logic              r_valid_b,
  input  logic              clr,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              err_q;

  logic wacc_d;
  logic x_err_d;
  logic err_d;

  assign busy = (state_q == CLEAR);
  assign err  = err_q;

  assign wacc_d = w_en & ~busy &
                  ~(ZR & (w_addr == '0));

  // Catches unknown write controls in simulation; constant 0 in hardware.
  assign x_err_d = (w_en !== 1'b0) &&
                   ((^{w_en, w_addr, w_data}) === 1'bx);

  assign err_d = (w_en == 1'b1 &&
                  (busy || (ZR && w_addr == '0)))
                 || x_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      err_q     <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (err_d) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
          end
        end
        CLEAR: begin
          mem_q[clr_ptr_q]   <= '0;
          valid_q[clr_ptr_q] <= 1'b0;
          if (clr_ptr_q == LAST) begin
            state_q <= IDLE;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (wacc_d) begin
        mem_q[w_addr]   <= w_data;
        valid_q[w_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    r_data_a  = mem_q[r_addr_a];
    r_valid_a = valid_q[r_addr_a];
    if (BYP && wacc_d && w_addr == r_addr_a) begin
      r_data_a  = w_data;
      r_valid_a = 1'b1;
    end
    if (ZR && r_addr_a == '0) begin
      r_data_a  = '0;
      r_valid_a = 1'b1;
    end
  end

  always_comb begin
    r_data_b  = mem_q[r_addr_b];
    r_valid_b = valid_q[r_addr_b];
    if (BYP && wacc_d && w_addr == r_addr_b) begin
      r_data_b  = w_data;
      r_valid_b = 1'b1;
    end
    if (ZR && r_addr_b == '0) begin
      r_data_b  = '0;
      r_valid_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed table, clear/reset sequences,
// and random traffic against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [2:0]  w_addr;
  logic [14:0] w_data;
  logic [2:0]  ra, rb;
  logic        clr;

  logic [14:0] da, db, nda, ndb;
  logic        va, vb, nva, nvb;
  logic        busy, err, nbusy, nerr;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 0;

  logic [14:0] m [8];
  bit          v [8];
  int          bcnt;
  bit          merr;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(15), .ADDR_W(3),
                 .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(ra), .r_data_a(da), .r_valid_a(va),
    .r_addr_b(rb), .r_data_b(db), .r_valid_b(vb),
    .clr(clr), .busy(busy), .err(err)
  );

  regfile_2r1w #(.DATA_W(15), .ADDR_W(3),
                 .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(ra), .r_data_a(nda), .r_valid_a(nva),
    .r_addr_b(rb), .r_data_b(ndb), .r_valid_b(nvb),
    .clr(clr), .busy(nbusy), .err(nerr)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(
      input logic [2:0] a, input bit byp);
    if (a == 3'd0) return {1'b1, 15'h0};
    if (byp && w_en && bcnt == 0 &&
        w_addr != 3'd0 && w_addr == a)
      return {1'b1, w_data};
    return {v[a], m[a]};
  endfunction

  task automatic model_edge();
    int idx;
    bit wa;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m[i] = '0;
        v[i] = 0;
      end
      bcnt = 0;
      merr = 0;
    end else begin
      if (w_en && (bcnt > 0 || w_addr == 3'd0))
        merr = 1;
      wa = w_en && bcnt == 0 && w_addr != 3'd0;
      if (bcnt > 0) begin
        idx = 8 - bcnt;
        m[idx] = '0;
        v[idx] = 0;
        bcnt--;
      end else if (clr) begin
        bcnt = 8;
      end
      if (wa) begin
        m[w_addr] = w_data;
        v[w_addr] = 1;
      end
    end
  endtask

  task automatic set_in(input bit we, input logic [2:0] wa,
                        input logic [14:0] wd,
                        input logic [2:0] a, input logic [2:0] b,
                        input bit c);
    w_en = we; w_addr = wa; w_data = wd;
    ra = a; rb = b; clr = c;
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cycle();
    logic [15:0] e;
    #2;
    if (chk_en) begin
      e = exp_rd(ra, 1);
      chk("rd_a", {va, da}, e);
      e = exp_rd(rb, 1);
      chk("rd_b", {vb, db}, e);
      e = exp_rd(ra, 0);
      chk("nb_rd_a", {nva, nda}, e);
      e = exp_rd(rb, 0);
      chk("nb_rd_b", {nvb, ndb}, e);
      chk("busy", busy, bcnt > 0);
      chk("err", err, merr);
      chk("nb_busy", nbusy, bcnt > 0);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  wa;
    logic [14:0] wd;
    logic [2:0]  a, b;
    logic [14:0] ea, eb;
    bit          eva, evb;
  } vec_t;

  vec_t tbl [6];
  int n;

  initial begin
    tbl[0] = '{1, 3, 15'h1234, 3, 3, 15'h1234, 15'h1234, 1, 1};
    tbl[1] = '{0, 0, 15'h0,    3, 1, 15'h1234, 15'h0,    1, 0};
    tbl[2] = '{1, 0, 15'h7FFF, 0, 3, 15'h0,    15'h1234, 1, 1};
    tbl[3] = '{0, 0, 15'h0,    0, 0, 15'h0,    15'h0,    1, 1};
    tbl[4] = '{1, 5, 15'h0055, 5, 2, 15'h0055, 15'h0,    1, 0};
    tbl[5] = '{0, 0, 15'h0,    5, 3, 15'h0055, 15'h1234, 1, 1};

    rst = 1;
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;
    chk_en = 1;

    // Reset state sweep on both ports.
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(7 - i), 0);
      cycle();
    end
    chk("err_after_rst", err, 0);

    // Directed table: bypass, zero entry, storage.
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd,
             tbl[i].a, tbl[i].b, 0);
      #2;
      chk("tbl_a", {va, da}, {tbl[i].eva, tbl[i].ea});
      chk("tbl_b", {vb, db}, {tbl[i].evb, tbl[i].eb});
      if (i == 0)
        chk("tbl_nobyp", {nva, nda}, 16'h0);
      cycle();
    end
    chk("err_sticky", err, 1);

    // Fill all entries then clear.
    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'(i), 15'(16'h100 + i), 3'(i), 0, 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 1);
    cycle();
    n = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      set_in(0, 0, 0, 3'(k), 3'(k - 1), 0);
      n++;
      cycle();
    end
    chk("busy_len", n, 8);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(i), 0);
      cycle();
    end

    // Write and re-clr during a clear sequence.
    rst = 1; set_in(0, 0, 0, 0, 0, 0); cycle();
    rst = 0;
    set_in(1, 5, 15'h0A5A, 5, 5, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    n = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (k == 2) set_in(1, 5, 15'h7777, 5, 5, 0);
      else if (k == 4) set_in(0, 0, 0, 5, 6, 1);
      else set_in(0, 0, 0, 5, 3'(k), 0);
      n++;
      cycle();
    end
    chk("busy_len_noretrig", n, 8);
    chk("err_busy_write", err, 1);

    // Reset on the third clear cycle.
    for (int i = 1; i < 8; i++) begin
      set_in(1, 3'(i), 15'(16'h2000 + i), 0, 0, 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0); cycle(); cycle();
    rst = 1; cycle();
    rst = 0;
    chk("busy_after_rst", busy, 0);
    chk("err_after_rst2", err, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 3'(i), 3'(i), 0);
      cycle();
    end

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 1),
             3'($urandom_range(0, 7)),
             15'($urandom),
             3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)),
             $urandom_range(0, 24) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
